mem_ctrl: RTL and testbench

//  Sequences the single byte-wide RAM port between the instruction-fetch stage (32-bit fetch)
//  and the MEM stage (LB/LH/LW/LBU/LHU loads, SB/SH/SW stores).

---
 rtl/mem_ctrl_if.sv | 41 ++++
 rtl/mem_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_mem_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if
//   Requester-side bundle of the memory controller: the instruction-fetch
//   port and the MEM-stage load/store port.
//   Modports:
//     master : pipeline side, drives requests, receives done/data
//     slave  : controller side, receives requests, drives done/data
//   Signals:
//     if_req, if_addr           fetch request and byte address
//     if_done, if_inst          fetch completion pulse and fetched word
//     mem_req, mem_we           MEM request, 1 = store / 0 = load
//     mem_addr, mem_size        byte address, 0 = byte, 1 = half, 2/3 = word
//     mem_sign, mem_wdata       load sign-extend select, store data
//     mem_done, mem_rdata       MEM completion pulse and extended load data
interface mem_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_done;
  logic [31:0]       if_inst;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [1:0]        mem_size;
  logic              mem_sign;
  logic [31:0]       mem_wdata;
  logic              mem_done;
  logic [31:0]       mem_rdata;

  modport master (
    output if_req, if_addr,
    output mem_req, mem_we, mem_addr, mem_size, mem_sign, mem_wdata,
    input  if_done, if_inst, mem_done, mem_rdata
  );

  modport slave (
    input  if_req, if_addr,
    input  mem_req, mem_we, mem_addr, mem_size, mem_sign, mem_wdata,
    output if_done, if_inst, mem_done, mem_rdata
  );
endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl
//   Shares one byte-wide RAM port between instruction fetch (always 4 bytes)
//   and MEM-stage loads/stores (1, 2 or 4 bytes). Each access is split into
//   byte transfers at addr+i (wrapping, misalignment allowed). Loads are
//   assembled little-endian and sign/zero extended; stores are serialised.
//   MEM requests win over fetch when both are pending in IDLE.
// Ports:
//   clk       clock, all state on rising edge
//   rst       synchronous active-high reset
//   rdy       run enable; low freezes all state and suppresses ram_wr
//   bus       mem_ctrl_if.slave requester bundle (fetch + MEM ports)
//   busy      high whenever the controller is not IDLE
//   ram_a     registered RAM byte address
//   ram_dout  registered RAM write byte
//   ram_wr    RAM write strobe
//   ram_din   RAM read byte, valid the cycle after ram_a presents it
module mem_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  mem_ctrl_if.slave         bus,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_a,
  output logic [7:0]        ram_dout,
  output logic              ram_wr,
  input  logic [7:0]        ram_din
);

  typedef enum logic [1:0] {IDLE, RD_ISSUE, RD_TAIL, WR} state_t;

  state_t            state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [1:0]        last_q, last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              for_mem_q, for_mem_d;
  logic              sign_q, sign_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rd_buf_q, rd_buf_d;
  logic [ADDR_W-1:0] ram_a_q, ram_a_d;
  logic [7:0]        ram_dout_q, ram_dout_d;
  logic              wr_q, wr_d;
  logic              if_done_q, if_done_d;
  logic              mem_done_q, mem_done_d;
  logic [31:0]       if_inst_q, if_inst_d;
  logic [31:0]       mem_rdata_q, mem_rdata_d;
  logic [1:0]        idx_nx, idx_prev;
  logic [31:0]       word;

  // Index of the last byte of an access: 0 for byte, 1 for half, 3 for word.
  function automatic logic [1:0] last_idx(input logic [1:0] size);
    case (size)
      2'd0:    last_idx = 2'd0;
      2'd1:    last_idx = 2'd1;
      default: last_idx = 2'd3;
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] w, input logic [1:0] last,
                                         input logic sign);
    case (last)
      2'd0:    extend = {{24{sign & w[7]}}, w[7:0]};
      2'd1:    extend = {{16{sign & w[15]}}, w[15:0]};
      default: extend = w;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      last_q      <= '0;
      addr_q      <= '0;
      for_mem_q   <= 1'b0;
      sign_q      <= 1'b0;
      wdata_q     <= '0;
      rd_buf_q    <= '0;
      ram_a_q     <= '0;
      ram_dout_q  <= '0;
      wr_q        <= 1'b0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      if_inst_q   <= '0;
      mem_rdata_q <= '0;
    end else if (rdy) begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      last_q      <= last_d;
      addr_q      <= addr_d;
      for_mem_q   <= for_mem_d;
      sign_q      <= sign_d;
      wdata_q     <= wdata_d;
      rd_buf_q    <= rd_buf_d;
      ram_a_q     <= ram_a_d;
      ram_dout_q  <= ram_dout_d;
      wr_q        <= wr_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
      if_inst_q   <= if_inst_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    last_d      = last_q;
    addr_d      = addr_q;
    for_mem_d   = for_mem_q;
    sign_d      = sign_q;
    wdata_d     = wdata_q;
    rd_buf_d    = rd_buf_q;
    ram_a_d     = ram_a_q;
    ram_dout_d  = ram_dout_q;
    wr_d        = 1'b0;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;
    if_inst_d   = if_inst_q;
    mem_rdata_d = mem_rdata_q;
    idx_nx      = idx_q + 2'd1;
    idx_prev    = idx_q - 2'd1;
    // In RD_TAIL idx_q is the last byte, so this is the complete word.
    word        = rd_buf_q;
    word[{idx_q, 3'b000} +: 8] = ram_din;

    case (state_q)
      IDLE: begin
        // A requester whose done is pulsing right now is still holding its
        // request from the finished access; ignore it for this cycle.
        if (bus.mem_req && !mem_done_q) begin
          idx_d     = 2'd0;
          last_d    = last_idx(bus.mem_size);
          addr_d    = bus.mem_addr;
          for_mem_d = 1'b1;
          sign_d    = bus.mem_sign;
          wdata_d   = bus.mem_wdata;
          rd_buf_d  = '0;
          ram_a_d   = bus.mem_addr;
          if (bus.mem_we) begin
            state_d    = WR;
            wr_d       = 1'b1;
            ram_dout_d = bus.mem_wdata[7:0];
          end else begin
            state_d = RD_ISSUE;
          end
        end else if (bus.if_req && !if_done_q) begin
          idx_d     = 2'd0;
          last_d    = 2'd3;
          addr_d    = bus.if_addr;
          for_mem_d = 1'b0;
          sign_d    = 1'b0;
          rd_buf_d  = '0;
          ram_a_d   = bus.if_addr;
          state_d   = RD_ISSUE;
        end
      end
      RD_ISSUE: begin
        // ram_din now carries the byte addressed one cycle earlier.
        if (idx_q != 2'd0) begin
          rd_buf_d[{idx_prev, 3'b000} +: 8] = ram_din;
        end
        if (idx_q == last_q) begin
          state_d = RD_TAIL;
        end else begin
          idx_d   = idx_nx;
          ram_a_d = addr_q + ADDR_W'(idx_nx);
        end
      end
      RD_TAIL: begin
        state_d = IDLE;
        if (for_mem_q) begin
          mem_done_d  = 1'b1;
          mem_rdata_d = extend(word, last_q, sign_q);
        end else begin
          if_done_d = 1'b1;
          if_inst_d = word;
        end
      end
      WR: begin
        if (idx_q == last_q) begin
          state_d    = IDLE;
          mem_done_d = 1'b1;
        end else begin
          idx_d      = idx_nx;
          ram_a_d    = addr_q + ADDR_W'(idx_nx);
          ram_dout_d = wdata_q[{idx_nx, 3'b000} +: 8];
          wr_d       = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy          = (state_q != IDLE);
  assign ram_a         = ram_a_q;
  assign ram_dout      = ram_dout_q;
  assign ram_wr        = wr_q & rdy;
  assign bus.if_done   = if_done_q;
  assign bus.if_inst   = if_inst_q;
  assign bus.mem_done  = mem_done_q;
  assign bus.mem_rdata = mem_rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl
//   Self-checking bench for mem_ctrl: reset values, a table of directed
//   load/store vectors, hand-written multi-cycle sequences (address stepping,
//   arbitration, rdy stall, reset mid-fetch, address wrap) and randomized
//   accesses checked against a byte-array memory model.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        busy;
  logic [31:0] ram_a;
  logic [7:0]  ram_dout;
  logic        ram_wr;
  logic [7:0]  ram_din;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0]  ram [logic [31:0]];
  logic [39:0] wr_log [$];

  mem_ctrl_if #(.ADDR_W(32)) bus ();

  mem_ctrl #(.ADDR_W(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .rdy      (rdy),
    .bus      (bus),
    .busy     (busy),
    .ram_a    (ram_a),
    .ram_dout (ram_dout),
    .ram_wr   (ram_wr),
    .ram_din  (ram_din)
  );

  always #5 clk = ~clk;

  // Unwritten locations read back a pattern derived from their address.
  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    if (ram.exists(a)) return ram[a];
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  // Synchronous RAM: read data appears the cycle after the address.
  always @(posedge clk) begin
    ram_din <= ram_rd(ram_a);
    if (ram_wr) begin
      ram[ram_a] = ram_dout;
      wr_log.push_back({ram_a, ram_dout});
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int n_of(input logic [1:0] size);
    return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
  endfunction

  // Reference load: gather n bytes little-endian, then extend arithmetically.
  function automatic logic [31:0] model_load(input logic [31:0] addr, input int n, input bit sign);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v = v | (32'(ram_rd(addr + 32'(i))) << (8 * i));
    if (sign && n < 4 && v[8 * n - 1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
    return v;
  endfunction

  task automatic preload(input logic [31:0] addr, input logic [31:0] w);
    for (int i = 0; i < 4; i++) ram[addr + 32'(i)] = w[8 * i +: 8];
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic checkWrites(input string tag, input logic [31:0] addr, input int n,
                             input logic [31:0] wdata);
    checkOutput({tag, " write count"}, 32'(wr_log.size()), 32'(n));
    for (int i = 0; i < n && i < wr_log.size(); i++) begin
      checkOutput($sformatf("%s write %0d addr", tag, i), wr_log[i][39:8], addr + 32'(i));
      checkOutput($sformatf("%s write %0d data", tag, i), 32'(wr_log[i][7:0]),
                  32'(wdata[8 * i +: 8]));
    end
  endtask

  // Issue one access, wait (bounded) for its done pulse, return data and latency.
  task automatic applyStimulus(input bit is_mem, input bit we, input logic [31:0] addr,
                               input logic [1:0] size, input bit sign, input logic [31:0] wdata,
                               output logic [31:0] data, output int lat);
    @(negedge clk);
    wr_log.delete();
    if (is_mem) begin
      bus.mem_req   = 1'b1;
      bus.mem_we    = we;
      bus.mem_addr  = addr;
      bus.mem_size  = size;
      bus.mem_sign  = sign;
      bus.mem_wdata = wdata;
    end else begin
      bus.if_req  = 1'b1;
      bus.if_addr = addr;
    end
    lat = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (is_mem ? bus.mem_done : bus.if_done) break;
    end
    data = is_mem ? bus.mem_rdata : bus.if_inst;
    bus.mem_req = 1'b0;
    bus.if_req  = 1'b0;
  endtask

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [1:0]  size;
    bit          sign;
    logic [31:0] wdata;
    logic [31:0] pre;
    logic [31:0] exp_word;
    int          exp_lat;
  } vec_t;

  vec_t vecs [12];

  initial begin
    logic [31:0] data, exp, addr, wdata, d_mem, d_if;
    int          lat, mem_lat, if_lat, n, seen;
    bit          is_mem, we, sign;
    logic [1:0]  size;

    rst = 1'b1;
    rdy = 1'b1;
    bus.if_req = 1'b0;   bus.if_addr = '0;
    bus.mem_req = 1'b0;  bus.mem_we = 1'b0; bus.mem_addr = '0;
    bus.mem_size = '0;   bus.mem_sign = 1'b0; bus.mem_wdata = '0;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("reset busy",      32'(busy), 32'd0);
    checkOutput("reset ram_a",     ram_a, 32'd0);
    checkOutput("reset ram_dout",  32'(ram_dout), 32'd0);
    checkOutput("reset ram_wr",    32'(ram_wr), 32'd0);
    checkOutput("reset if_done",   32'(bus.if_done), 32'd0);
    checkOutput("reset mem_done",  32'(bus.mem_done), 32'd0);
    checkOutput("reset if_inst",   bus.if_inst, 32'd0);
    checkOutput("reset mem_rdata", bus.mem_rdata, 32'd0);
    rst = 1'b0;

    // Directed vectors: we, addr, size, sign, wdata, preload, expected word, latency
    vecs[0]  = '{1'b0, 32'h100, 2'd2, 1'b0, 32'h0,        32'h12345678, 32'h12345678, 6};
    vecs[1]  = '{1'b0, 32'h20,  2'd0, 1'b1, 32'h0,        32'h00000080, 32'hFFFFFF80, 3};
    vecs[2]  = '{1'b0, 32'h20,  2'd0, 1'b0, 32'h0,        32'h00000080, 32'h00000080, 3};
    vecs[3]  = '{1'b0, 32'h30,  2'd1, 1'b1, 32'h0,        32'h00009234, 32'hFFFF9234, 4};
    vecs[4]  = '{1'b0, 32'h30,  2'd1, 1'b0, 32'h0,        32'h00009234, 32'h00009234, 4};
    vecs[5]  = '{1'b1, 32'h40,  2'd1, 1'b0, 32'hAABBCCDD, 32'h44332211, 32'h4433CCDD, 3};
    vecs[6]  = '{1'b1, 32'h50,  2'd0, 1'b0, 32'h000000A5, 32'hDDCCBBAA, 32'hDDCCBBA5, 2};
    vecs[7]  = '{1'b1, 32'h61,  2'd2, 1'b0, 32'hDEADBEEF, 32'h00000000, 32'hDEADBEEF, 5};
    vecs[8]  = '{1'b0, 32'h63,  2'd3, 1'b1, 32'h0,        32'hF00DCAFE, 32'hF00DCAFE, 6};
    vecs[9]  = '{1'b0, 32'h70,  2'd1, 1'b1, 32'h0,        32'h00007F01, 32'h00007F01, 4};
    vecs[10] = '{1'b0, 32'h80,  2'd0, 1'b1, 32'h0,        32'h0000007F, 32'h0000007F, 3};
    vecs[11] = '{1'b0, 32'h90,  2'd1, 1'b0, 32'h0,        32'h1234F00D, 32'h0000F00D, 4};

    for (int v = 0; v < 12; v++) begin
      preload(vecs[v].addr, vecs[v].pre);
      applyStimulus(1'b1, vecs[v].we, vecs[v].addr, vecs[v].size, vecs[v].sign,
                    vecs[v].wdata, data, lat);
      checkOutput($sformatf("vec%0d latency", v), 32'(lat), 32'(vecs[v].exp_lat));
      if (vecs[v].we)
        checkOutput($sformatf("vec%0d ram word", v), model_load(vecs[v].addr, 4, 1'b0),
                    vecs[v].exp_word);
      else
        checkOutput($sformatf("vec%0d rdata", v), data, vecs[v].exp_word);
    end

    // LW address stepping, busy window and done timing
    preload(32'h100, 32'h12345678);
    @(negedge clk);
    bus.mem_req = 1'b1; bus.mem_we = 1'b0; bus.mem_addr = 32'h100;
    bus.mem_size = 2'd2; bus.mem_sign = 1'b0;
    for (int j = 1; j <= 6; j++) begin
      @(negedge clk);
      if (j <= 4) checkOutput($sformatf("lw ram_a T+%0d", j), ram_a, 32'h100 + 32'(j - 1));
      checkOutput($sformatf("lw busy T+%0d", j), 32'(busy), (j <= 5) ? 32'd1 : 32'd0);
      checkOutput($sformatf("lw mem_done T+%0d", j), 32'(bus.mem_done), (j == 6) ? 32'd1 : 32'd0);
    end
    checkOutput("lw rdata", bus.mem_rdata, 32'h12345678);
    bus.mem_req = 1'b0;

    // Simultaneous requests: MEM first, fetch accepted in the mem_done cycle
    preload(32'h0, 32'h00000013);
    preload(32'h20, 32'h00000080);
    @(negedge clk);
    bus.mem_req = 1'b1; bus.mem_we = 1'b0; bus.mem_addr = 32'h20;
    bus.mem_size = 2'd0; bus.mem_sign = 1'b1;
    bus.if_req = 1'b1; bus.if_addr = 32'h0;
    mem_lat = -1; if_lat = -1; d_mem = '0; d_if = '0;
    for (int c = 1; c <= 40 && if_lat < 0; c++) begin
      @(negedge clk);
      if (bus.mem_done && mem_lat < 0) begin
        mem_lat = c; d_mem = bus.mem_rdata; bus.mem_req = 1'b0;
      end
      if (bus.if_done) begin
        if_lat = c; d_if = bus.if_inst; bus.if_req = 1'b0;
      end
    end
    bus.mem_req = 1'b0; bus.if_req = 1'b0;
    checkOutput("arb mem latency", 32'(mem_lat), 32'd3);
    checkOutput("arb fetch latency", 32'(if_lat), 32'd9);
    checkOutput("arb mem rdata", d_mem, 32'hFFFFFF80);
    checkOutput("arb if_inst", d_if, 32'h00000013);

    // rdy low for 3 cycles in the middle of a SW
    @(negedge clk);
    wr_log.delete();
    bus.mem_req = 1'b1; bus.mem_we = 1'b1; bus.mem_addr = 32'h200;
    bus.mem_size = 2'd2; bus.mem_wdata = 32'hCAFEBABE;
    @(negedge clk);
    checkOutput("stall ram_wr before", 32'(ram_wr), 32'd1);
    @(negedge clk);
    rdy = 1'b0;
    @(negedge clk);
    checkOutput("stall ram_wr T+3", 32'(ram_wr), 32'd0);
    @(negedge clk);
    checkOutput("stall ram_wr T+4", 32'(ram_wr), 32'd0);
    @(negedge clk);
    rdy = 1'b1;
    lat = 5;
    while (!bus.mem_done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    bus.mem_req = 1'b0;
    checkOutput("stall done latency", 32'(lat), 32'd8);
    checkWrites("stall", 32'h200, 4, 32'hCAFEBABE);

    // Reset in the middle of a fetch
    @(negedge clk);
    bus.if_req = 1'b1; bus.if_addr = 32'h300;
    repeat (2) @(negedge clk);
    rst = 1'b1; bus.if_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rst busy", 32'(busy), 32'd0);
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.if_done) seen++;
    end
    checkOutput("rst no if_done", 32'(seen), 32'd0);
    exp = model_load(32'h300, 4, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h300, 2'd2, 1'b0, 32'h0, data, lat);
    checkOutput("post-rst fetch latency", 32'(lat), 32'd6);
    checkOutput("post-rst fetch data", data, exp);

    // Fetch wrapping past the top of the address space
    @(negedge clk);
    exp = model_load(32'hFFFFFFFE, 4, 1'b0);
    bus.if_req = 1'b1; bus.if_addr = 32'hFFFFFFFE;
    lat = 0;
    while (!bus.if_done && lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat <= 4) checkOutput($sformatf("wrap ram_a T+%0d", lat), ram_a,
                                32'hFFFFFFFE + 32'(lat - 1));
    end
    data = bus.if_inst;
    bus.if_req = 1'b0;
    checkOutput("wrap latency", 32'(lat), 32'd6);
    checkOutput("wrap data", data, exp);

    // Randomized accesses against the memory model
    for (int r = 0; r < 60; r++) begin
      is_mem = ($urandom_range(0, 2) != 0);
      we     = is_mem && ($urandom_range(0, 1) == 1);
      size   = 2'($urandom_range(0, 3));
      sign   = 1'($urandom_range(0, 1));
      addr   = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFF0 + 32'($urandom_range(0, 15))
                                           : 32'h1000 + 32'($urandom_range(0, 255));
      wdata  = $urandom;
      n      = is_mem ? n_of(size) : 4;
      exp    = model_load(addr, n, is_mem && sign);
      applyStimulus(is_mem, we, addr, size, sign, wdata, data, lat);
      checkOutput($sformatf("rand%0d latency", r), 32'(lat), we ? 32'(n + 1) : 32'(n + 2));
      if (we) checkWrites($sformatf("rand%0d", r), addr, n, wdata);
      else    checkOutput($sformatf("rand%0d data", r), data, exp);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
